fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 126 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an 8-bit FIFO read port and sends each one as an 8N1 UART frame.
// Every output is driven from a register, so the serial line and the read strobe never glitch.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_enable,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_data,
  output logic               fifo_rd_en,
  output logic               tx,
  output logic               busy,
  output logic               tx_done,
  output logic [COUNT_W-1:0] byte_count,
  output logic [2:0]         dbg_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      byte_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          tx     <= 1'b1;
          r_baud <= '0;
          if (tx_enable && !fifo_empty) begin
            r_state    <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          fifo_rd_en <= 1'b0;
          r_state    <= LATCH;
        end
        // The FIFO registers data_out on the read edge, so it is valid here.
        LATCH: begin
          r_shift <= fifo_data;
          r_baud  <= '0;
          tx      <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_idx   <= '0;
            tx      <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_idx == 3'd7) begin
              tx      <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              tx      <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          // Raise tx_done one edge early so it is high exactly on the final stop cycle.
          if (r_baud == BAUD_PRE) begin
            tx_done    <= 1'b1;
            byte_count <= byte_count + COUNT_W'(1);
          end
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            tx_done <= 1'b0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_baud     <= '0;
          fifo_rd_en <= 1'b0;
          tx         <= 1'b1;
          busy       <= 1'b0;
          tx_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4 and COUNT_W=4, fed by a small FIFO model
// that has a registered data_out and an empty flag lagging its count by one edge.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [CW-1:0] byte_count;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [7:0] fifo_q[$];
  logic       emp_d = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       chk_gap;
    int         exp_count;
  } vec_t;

  vec_t vecs[19];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .tx_done(tx_done), .byte_count(byte_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    emp_d      <= (fifo_q.size() == 0);
    fifo_empty <= emp_d;
  end

  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt++;
  end

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo_q.push_back(b);
  endtask

  task automatic idle_cycles(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
  endtask

  // Waits for the read strobe, then checks the whole frame cycle by cycle.
  task automatic run_frame(input logic [7:0] exp, input int drop_at,
                           output int wait_n, output int bad, output int done_bad);
    logic exp_tx;
    wait_n = 0;
    bad = 0;
    done_bad = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (fifo_rd_en !== 1'b1 && wait_n < 200);
    if (fifo_rd_en !== 1'b1) begin
      bad = 99;
      return;
    end
    if (busy !== 1'b1) bad++;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 1)       exp_tx = 1'b1;
      else if (k <= 5)  exp_tx = 1'b0;
      else if (k <= 37) exp_tx = exp[(k - 6) / 4];
      else              exp_tx = 1'b1;
      if (tx !== exp_tx || busy !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
      if (tx_done !== (k == 41)) done_bad++;
      if (k == drop_at) tx_enable = 1'b0;
    end
  endtask

  initial begin
    int wait_n, bad, done_bad, rd0, done0;

    vecs[0] = '{8'h00, 1'b0, 2};
    vecs[1] = '{8'hFF, 1'b1, 3};
    vecs[2] = '{8'h3C, 1'b1, 4};
    for (int i = 0; i < 16; i++)
      vecs[3 + i] = '{8'(i * 37 + 5), (i != 0), (i + 1) % 16};

    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_en", int'(fifo_rd_en), 0);
    check("reset_tx_done", int'(tx_done), 0);
    check("reset_count", int'(byte_count), 0);
    reset = 1'b1;
    tx_enable = 1'b1;
    idle_cycles(20, bad);
    check("idle_when_empty", bad, 0);
    check("idle_no_reads", rd_cnt, 0);

    push(8'hA5);
    run_frame(8'hA5, 0, wait_n, bad, done_bad);
    check("frame_a5_bits", bad, 0);
    check("frame_a5_tx_done", done_bad, 0);
    @(negedge clk);
    check("frame_a5_count", int'(byte_count), 1);
    check("frame_a5_reads", rd_cnt, 1);
    check("frame_a5_done_pulses", done_cnt, 1);

    for (int i = 0; i < 3; i++) fifo_q.push_back(vecs[i].data);
    for (int i = 0; i < 3; i++) begin
      run_frame(vecs[i].data, 0, wait_n, bad, done_bad);
      check($sformatf("b2b_bits_%0d", i), bad, 0);
      check($sformatf("b2b_tx_done_%0d", i), done_bad, 0);
      if (vecs[i].chk_gap) check($sformatf("b2b_gap_%0d", i), wait_n, 2);
      check($sformatf("b2b_count_%0d", i), int'(byte_count), vecs[i].exp_count);
    end
    idle_cycles(60, bad);
    check("b2b_idle_after_drain", bad, 0);
    check("b2b_total_reads", rd_cnt, 4);

    tx_enable = 1'b0;
    push(8'h11);
    push(8'h22);
    idle_cycles(30, bad);
    check("disabled_idle", bad, 0);
    check("disabled_no_reads", rd_cnt, 4);
    tx_enable = 1'b1;
    run_frame(8'h11, 15, wait_n, bad, done_bad);
    check("drop_en_bits", bad, 0);
    check("drop_en_tx_done", done_bad, 0);
    idle_cycles(60, bad);
    check("drop_en_idle", bad, 0);
    check("drop_en_reads", rd_cnt, 5);
    check("drop_en_count", int'(byte_count), 5);
    check("drop_en_left_in_fifo", fifo_q.size(), 1);

    fifo_q.delete();
    repeat (5) @(negedge clk);
    push(8'h5A);
    tx_enable = 1'b1;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (fifo_rd_en !== 1'b1 && wait_n < 200);
    check("rst_frame_started", int'(fifo_rd_en), 1);
    repeat (12) @(negedge clk);
    check("rst_in_data_state", int'(dbg_state), 4);
    reset = 1'b0;
    #1;
    check("rst_async_tx", int'(tx), 1);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_count", int'(byte_count), 0);
    @(negedge clk);
    reset = 1'b1;
    rd0 = rd_cnt;
    idle_cycles(60, bad);
    check("rst_no_partial_frame", bad, 0);
    check("rst_no_reads", rd_cnt - rd0, 0);
    check("rst_count_zero", int'(byte_count), 0);

    done0 = done_cnt;
    for (int i = 3; i < 19; i++) fifo_q.push_back(vecs[i].data);
    for (int i = 3; i < 19; i++) begin
      run_frame(vecs[i].data, 0, wait_n, bad, done_bad);
      check($sformatf("wrap_bits_%0d", i - 3), bad, 0);
      if (vecs[i].chk_gap) check($sformatf("wrap_gap_%0d", i - 3), wait_n, 2);
      check($sformatf("wrap_count_%0d", i - 3), int'(byte_count), vecs[i].exp_count);
    end
    @(negedge clk);
    check("wrap_done_pulses", done_cnt - done0, 16);
    check("wrap_final_count", int'(byte_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
